// File: rtl/aes_stream_scheduler_if.sv
// Bundle of request, core and response signals for the AES stream scheduler.
// master: producer/consumer/core side; slave: scheduler side.
interface aes_stream_scheduler_if #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4
);
    // request side
    logic              in_valid;
    logic              in_ready;
    logic              enc_or_dec;
    logic [2:0]        key_size;
    logic [DATA_W-1:0] message_in;
    logic [TAG_W-1:0]  in_tag;
    // core side
    logic              core_start;
    logic              core_enc_or_dec;
    logic [2:0]        core_key_size;
    logic [DATA_W-1:0] core_message_in;
    logic              core_done;
    logic [DATA_W-1:0] core_message_out;
    // response side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] message_out;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic              busy;

    modport master (
        output in_valid, enc_or_dec, key_size, message_in, in_tag,
        output core_done, core_message_out, out_ready,
        input  in_ready, core_start, core_enc_or_dec, core_key_size, core_message_in,
        input  out_valid, message_out, out_tag, out_err, busy
    );

    modport slave (
        input  in_valid, enc_or_dec, key_size, message_in, in_tag,
        input  core_done, core_message_out, out_ready,
        output in_ready, core_start, core_enc_or_dec, core_key_size, core_message_in,
        output out_valid, message_out, out_tag, out_err, busy
    );
endinterface

// File: rtl/aes_stream_scheduler.sv
// Streaming front-end for an AES core: request FIFO, single-block-in-flight
// issue FSM with key-size validation and core watchdog, tagged result register.
module aes_stream_scheduler #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_stream_scheduler_if.slave sched_if
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic              enc;
        logic [2:0]        key;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] msg;
    } req_t;

    req_t              fifo_mem [FIFO_DEPTH];
    req_t              req_in;
    req_t              issue_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              key_valid;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [DATA_W-1:0] out_msg_q, out_msg_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_err_q, out_err_d;

    assign req_in     = {sched_if.enc_or_dec, sched_if.key_size, sched_if.in_tag, sched_if.message_in};
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full FIFO refuses pushes even when the head is popped in the same cycle.
    assign fifo_push  = sched_if.in_valid && !fifo_full;
    assign key_valid  = (issue_q.key == 3'b100) || (issue_q.key == 3'b010) || (issue_q.key == 3'b001);

    // Request storage: plain array so it maps onto RAM; written on accepted pushes.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= req_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue register: registered read of the FIFO head; holds the block seen by the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= '0;
        end else if (fifo_pop) begin
            issue_q <= fifo_mem[rd_ptr_q];
        end
    end

    // State, watchdog and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wdog_q    <= '0;
            out_msg_q <= '0;
            out_tag_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            out_msg_q <= out_msg_d;
            out_tag_q <= out_tag_d;
            out_err_q <= out_err_d;
        end
    end

    // Next-state logic: pops, watchdog counting and result capture.
    // The watchdog counts cycles since the core_start cycle (which is count 0).
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        out_msg_d = out_msg_q;
        out_tag_d = out_tag_q;
        out_err_d = out_err_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (key_valid) begin
                    wdog_d  = '0;
                    state_d = ST_ISSUE;
                end else begin
                    out_msg_d = '0;
                    out_tag_d = issue_q.tag;
                    out_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_ISSUE: begin
                wdog_d  = wdog_q + WD_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done wins over a coincident timeout
                if (sched_if.core_done) begin
                    out_msg_d = sched_if.core_message_out;
                    out_tag_d = issue_q.tag;
                    out_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (wdog_q == WD_LAST) begin
                    out_msg_d = '0;
                    out_tag_d = issue_q.tag;
                    out_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                if (sched_if.out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sched_if.in_ready        = !fifo_full;
    assign sched_if.core_start      = (state_q == ST_ISSUE);
    assign sched_if.core_enc_or_dec = issue_q.enc;
    assign sched_if.core_key_size   = issue_q.key;
    assign sched_if.core_message_in = issue_q.msg;
    assign sched_if.out_valid       = (state_q == ST_RESP);
    assign sched_if.message_out     = out_msg_q;
    assign sched_if.out_tag         = out_tag_q;
    assign sched_if.out_err         = out_err_q;
    assign sched_if.busy            = !fifo_empty || (state_q != ST_IDLE);
endmodule
